// File: rtl/seg16_pkg.sv
// Shared constants for the 16-segment display blocks: glyph patterns and
// the sequencer state encoding. Patterns are active-low, bit15..0 = a..r.
package seg16_pkg;

    localparam logic [15:0] SEG16_BLANK = 16'hFFFF;

    localparam logic [15:0] SEG16_0 = 16'h00FF;
    localparam logic [15:0] SEG16_1 = 16'hCFFF;
    localparam logic [15:0] SEG16_2 = 16'h11E7;
    localparam logic [15:0] SEG16_3 = 16'h03E7;
    localparam logic [15:0] SEG16_4 = 16'hCEE7;
    localparam logic [15:0] SEG16_5 = 16'h22E7;
    localparam logic [15:0] SEG16_6 = 16'h20E7;
    localparam logic [15:0] SEG16_7 = 16'h0FFF;
    localparam logic [15:0] SEG16_8 = 16'h00E7;
    localparam logic [15:0] SEG16_9 = 16'h02E7;

    localparam logic [15:0] SEG16_A = 16'h0CE7;
    localparam logic [15:0] SEG16_B = 16'hE0E7;
    localparam logic [15:0] SEG16_C = 16'h30FF;
    localparam logic [15:0] SEG16_D = 16'hC1E7;
    localparam logic [15:0] SEG16_E = 16'h30EF;
    localparam logic [15:0] SEG16_F = 16'h3CEF;

    localparam logic [15:0] SEG16_DASH = 16'hFFE7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/seg16_message_sequencer_if.sv
// Byte stream handshake into the message sequencer: the sender owns
// byte_in/byte_valid, the sequencer answers with byte_ready.
interface seg16_message_sequencer_if;

    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );

endinterface

// File: rtl/seg16_char_rom.sv
// Combinational ASCII to active-low 16-segment glyph lookup.
// Unknown codes map to blank so they still occupy a display slot.
module seg16_char_rom
    import seg16_pkg::*;
(
    input  logic [7:0]  ascii,
    output logic [15:0] pattern
);

    always_comb begin
        pattern = SEG16_BLANK;
        case (ascii)
            8'h30: pattern = SEG16_0;
            8'h31: pattern = SEG16_1;
            8'h32: pattern = SEG16_2;
            8'h33: pattern = SEG16_3;
            8'h34: pattern = SEG16_4;
            8'h35: pattern = SEG16_5;
            8'h36: pattern = SEG16_6;
            8'h37: pattern = SEG16_7;
            8'h38: pattern = SEG16_8;
            8'h39: pattern = SEG16_9;
            // Hex letters are case-insensitive
            8'h41, 8'h61: pattern = SEG16_A;
            8'h42, 8'h62: pattern = SEG16_B;
            8'h43, 8'h63: pattern = SEG16_C;
            8'h44, 8'h64: pattern = SEG16_D;
            8'h45, 8'h65: pattern = SEG16_E;
            8'h46, 8'h66: pattern = SEG16_F;
            8'h2D: pattern = SEG16_DASH;
            default: pattern = SEG16_BLANK;
        endcase
    end

endmodule

// File: rtl/seg16_message_sequencer.sv
// Buffers ASCII bytes in a FIFO and shows each one on a 16-segment pattern
// for a fixed dwell, followed by a blank gap between characters.
module seg16_message_sequencer
    import seg16_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int DWELL_CYCLES = 12000000,
    parameter int GAP_CYCLES   = 1200000
) (
    input  logic                      CLK,
    input  logic                      reset,
    seg16_message_sequencer_if.slave  byte_if,
    input  logic                      flush,
    output logic [15:0]               segments,
    output logic                      char_strobe,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      busy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int CMAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2((CMAX > 2) ? CMAX : 2);

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          level_nz;
    logic [15:0]   head_pattern;

    seq_state_t    state;
    seq_state_t    state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [15:0]   segments_next;
    logic          strobe_next;

    assign level_nz           = (level != '0);
    assign byte_if.byte_ready = (level != LW'(DEPTH));
    assign push               = byte_if.byte_valid && byte_if.byte_ready && !flush;
    assign busy               = (state != IDLE) || level_nz;

    seg16_char_rom u_char_rom (
        .ascii   (mem[rd_ptr]),
        .pattern (head_pattern)
    );

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= byte_if.byte_in;
        end
    end

    // Flush only clears the queue; the character already on display is untouched
    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            segments    <= SEG16_BLANK;
            char_strobe <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            segments    <= segments_next;
            char_strobe <= strobe_next;
        end
    end

    // The last counted cycle of SHOW or GAP is where the next character is popped
    always_comb begin
        state_next = state;
        count_next = count;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (level_nz) begin
                    pop        = 1'b1;
                    count_next = DWELL_LOAD;
                    state_next = SHOW;
                end
            end
            SHOW: begin
                if (count != '0) begin
                    count_next = count - 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    count_next = GAP_LOAD;
                    state_next = GAP;
                end else if (level_nz) begin
                    pop        = 1'b1;
                    count_next = DWELL_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                if (count != '0) begin
                    count_next = count - 1'b1;
                end else if (level_nz) begin
                    pop        = 1'b1;
                    count_next = DWELL_LOAD;
                    state_next = SHOW;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        segments_next = segments;
        strobe_next   = 1'b0;
        if (pop) begin
            segments_next = head_pattern;
            strobe_next   = 1'b1;
        end else if (state_next != SHOW) begin
            segments_next = SEG16_BLANK;
        end
    end

endmodule

// File: tb/tb_seg16_message_sequencer.sv
// Bench for seg16_message_sequencer: directed vector table, corner sequences
// and random traffic against a timeline-based reference model.
module tb_seg16_message_sequencer;

    localparam int DEPTH = 4;
    localparam int DWELL = 4;
    localparam int GAP   = 2;
    localparam int NV    = 20;

    logic        CLK;
    logic        reset;
    logic        flush;
    logic [15:0] segments;
    logic        char_strobe;
    logic [2:0]  level;
    logic        busy;

    seg16_message_sequencer_if byte_if ();

    seg16_message_sequencer #(
        .DEPTH        (DEPTH),
        .DWELL_CYCLES (DWELL),
        .GAP_CYCLES   (GAP)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .byte_if     (byte_if),
        .flush       (flush),
        .segments    (segments),
        .char_strobe (char_strobe),
        .level       (level),
        .busy        (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: queue contents plus the cycle of the most recent pop.
    logic [7:0]  mq[$];
    int          lastPop = -100;
    int          cyc = 0;
    logic [15:0] curPat = 16'hFFFF;

    int          strobes = 0;
    logic [15:0] shown[$];

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        fl;
        logic        rs;
        logic [15:0] seg;
        logic        strobe;
        int          lvl;
        logic        rdy;
        logic        bsy;
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [15:0] tbEncode(input logic [7:0] c);
        case (c)
            8'h30: return 16'h00FF;
            8'h31: return 16'hCFFF;
            8'h32: return 16'h11E7;
            8'h33: return 16'h03E7;
            8'h34: return 16'hCEE7;
            8'h35: return 16'h22E7;
            8'h36: return 16'h20E7;
            8'h37: return 16'h0FFF;
            8'h38: return 16'h00E7;
            8'h39: return 16'h02E7;
            8'h41, 8'h61: return 16'h0CE7;
            8'h42, 8'h62: return 16'hE0E7;
            8'h43, 8'h63: return 16'h30FF;
            8'h44, 8'h64: return 16'hC1E7;
            8'h45, 8'h65: return 16'h30EF;
            8'h46, 8'h66: return 16'h3CEF;
            8'h2D: return 16'hFFE7;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic checkVal(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // A popped character is shown for DWELL cycles, then GAP blank cycles;
    // the next pop may happen on the last gap cycle.
    task automatic modelStep(input logic v, input logic [7:0] d, input logic fl, input logic rs);
        logic doPop;
        logic doPush;
        if (rs) begin
            mq.delete();
            lastPop = -100;
        end else begin
            doPop  = (mq.size() != 0) && (cyc >= lastPop + DWELL + GAP);
            doPush = v && (mq.size() != DEPTH) && !fl;
            if (doPop) begin
                curPat  = tbEncode(mq.pop_front());
                lastPop = cyc;
            end
            if (fl) mq.delete();
            else if (doPush) mq.push_back(d);
        end
        cyc++;
    endtask

    task automatic checkOutput();
        logic inShow;
        logic active;
        inShow = (cyc >= lastPop + 1) && (cyc <= lastPop + DWELL);
        active = (cyc >= lastPop + 1) && (cyc <= lastPop + DWELL + GAP);
        checkVal("segments", segments, inShow ? curPat : 16'hFFFF);
        checkVal("char_strobe", {15'b0, char_strobe}, {15'b0, cyc == lastPop + 1});
        checkVal("level", {13'b0, level}, 16'(mq.size()));
        checkVal("byte_ready", {15'b0, byte_if.byte_ready}, {15'b0, mq.size() != DEPTH});
        checkVal("busy", {15'b0, busy}, {15'b0, (mq.size() != 0) || active});
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic fl,
                                 input logic rs, output logic taken);
        byte_if.byte_valid = v;
        byte_if.byte_in    = d;
        flush              = fl;
        reset              = rs;
        taken = v && (byte_if.byte_ready === 1'b1) && !fl && !rs;
        @(posedge CLK);
        modelStep(v, d, fl, rs);
        @(negedge CLK);
        checkOutput();
        if (char_strobe === 1'b1) begin
            strobes++;
            shown.push_back(segments);
        end
    endtask

    task automatic idleCycles(input int n);
        logic t;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, t);
    endtask

    task automatic waitIdle(input int maxCycles);
        logic t;
        int n;
        n = 0;
        while (busy !== 1'b0 && n < maxCycles) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, t);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_timeout got busy=%b exp=0 after %0d cycles", busy, n);
        end
    endtask

    task automatic pushString(input string s);
        logic t;
        int i;
        int n;
        i = 0;
        n = 0;
        while (i < s.len() && n < 100) begin
            applyStimulus(1'b1, s[i], 1'b0, 1'b0, t);
            if (t) i++;
            n++;
        end
        byte_if.byte_valid = 1'b0;
        checkVal("push_all_taken", 16'(i), 16'(s.len()));
    endtask

    task automatic checkShown(input string name, input logic [15:0] exp[$]);
        checkVal({name, "_count"}, 16'(shown.size()), 16'(exp.size()));
        for (int i = 0; i < exp.size() && i < shown.size(); i++)
            checkVal($sformatf("%s_%0d", name, i), shown[i], exp[i]);
    endtask

    initial begin
        logic        t;
        logic        pending;
        logic [7:0]  pdata;
        int          sawFull;
        string       pool;
        logic [15:0] expQ[$];

        reset              = 1'b1;
        flush              = 1'b0;
        byte_if.byte_valid = 1'b0;
        byte_if.byte_in    = 8'h00;

        // inputs for one cycle -> outputs expected after that cycle's edge
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hFFFF, 1'b0, 0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 16'hFFFF, 1'b0, 0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFFFF, 1'b0, 0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h30, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h00FF, 1'b1, 0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h00FF, 1'b0, 0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h00FF, 1'b0, 0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h00FF, 1'b0, 0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFFFF, 1'b0, 0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFFFF, 1'b0, 0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'hFFFF, 1'b0, 0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h2D, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 8'h37, 1'b0, 1'b0, 16'hFFE7, 1'b1, 1, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 8'h39, 1'b0, 1'b0, 16'hFFE7, 1'b0, 2, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 8'h20, 1'b0, 1'b0, 16'hFFE7, 1'b0, 3, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 8'h35, 1'b0, 1'b0, 16'hFFE7, 1'b0, 4, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 8'h36, 1'b0, 1'b0, 16'hFFFF, 1'b0, 4, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 8'h36, 1'b0, 1'b0, 16'hFFFF, 1'b0, 4, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 8'h36, 1'b0, 1'b0, 16'h0FFF, 1'b1, 3, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 8'h36, 1'b0, 1'b0, 16'h0FFF, 1'b0, 4, 1'b0, 1'b1};

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].fl, vecs[i].rs, t);
            checkVal($sformatf("vec%0d_seg", i), segments, vecs[i].seg);
            checkVal($sformatf("vec%0d_strobe", i), {15'b0, char_strobe}, {15'b0, vecs[i].strobe});
            checkVal($sformatf("vec%0d_level", i), {13'b0, level}, 16'(vecs[i].lvl));
            checkVal($sformatf("vec%0d_ready", i), {15'b0, byte_if.byte_ready}, {15'b0, vecs[i].rdy});
            checkVal($sformatf("vec%0d_busy", i), {15'b0, busy}, {15'b0, vecs[i].bsy});
        end
        byte_if.byte_valid = 1'b0;
        waitIdle(200);

        $display("[TB] sequence: '1' then '8'");
        shown.delete();
        strobes = 0;
        pushString("18");
        waitIdle(100);
        checkVal("s18_strobes", 16'(strobes), 16'd2);
        expQ = '{16'hCFFF, 16'h00E7};
        checkShown("s18", expQ);

        $display("[TB] sequence: ABCDEF held against a full FIFO");
        shown.delete();
        sawFull = 0;
        begin
            string s;
            int i;
            int n;
            s = "ABCDEF";
            i = 0;
            n = 0;
            while (i < 6 && n < 200) begin
                applyStimulus(1'b1, s[i], 1'b0, 1'b0, t);
                if (t) i++;
                if (level == 3'd4) sawFull++;
                n++;
            end
            byte_if.byte_valid = 1'b0;
            checkVal("abcdef_taken", 16'(i), 16'd6);
        end
        checkVal("abcdef_saw_full", {15'b0, sawFull != 0}, 16'd1);
        waitIdle(200);
        expQ = '{16'h0CE7, 16'hE0E7, 16'h30FF, 16'hC1E7, 16'h30EF, 16'h3CEF};
        checkShown("abcdef", expQ);

        $display("[TB] sequence: unmapped 'Z' then 'a'");
        shown.delete();
        pushString("Za");
        waitIdle(100);
        expQ = '{16'hFFFF, 16'h0CE7};
        checkShown("za", expQ);

        $display("[TB] sequence: reset during dwell");
        shown.delete();
        pushString("123");
        checkVal("rst_first_shown", 16'(shown.size()), 16'd1);
        strobes = 0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, t);
        idleCycles(15);
        checkVal("rst_no_strobes", 16'(strobes), 16'd0);

        $display("[TB] sequence: flush during dwell");
        shown.delete();
        pushString("123");
        strobes = 0;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, t);
        waitIdle(100);
        checkVal("flush_no_strobes", 16'(strobes), 16'd0);

        $display("[TB] random traffic");
        pool = "0123456789ABCDEFabcdef- Zz!~";
        pending = 1'b0;
        pdata = 8'h00;
        for (int k = 0; k < 1500; k++) begin
            logic fl;
            logic rs;
            if (!pending && $urandom_range(0, 99) < 40) begin
                pending = 1'b1;
                if ($urandom_range(0, 9) == 0) pdata = 8'($urandom_range(0, 255));
                else pdata = pool[$urandom_range(0, pool.len() - 1)];
            end
            fl = ($urandom_range(0, 199) == 0);
            rs = ($urandom_range(0, 499) == 0);
            applyStimulus(pending, pdata, fl, rs, t);
            if (t || rs) pending = 1'b0;
        end
        byte_if.byte_valid = 1'b0;
        waitIdle(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
